trng_pool_buf: RTL and testbench

Parametrised, double-banked entropy collection buffer for the crypto TRNG path, the next generation of the single 256-bit collection buffer. Samples of IN_W bits from the digitiser are shifted into one bank while software or the post-processor drains the other (ping-pong), so collection continues during readout. In DRNG mode, software loads bank 0 word-by-word instead. Samples arriving while no bank can accept them are counted.

---
 rtl/trng_pool_buf.sv | 146 ++++++++++++++
 tb/tb_trng_pool_buf.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/trng_pool_buf.sv
// Double-banked entropy pool: digitiser samples shift into one bank while the other is drained.
// In DRNG mode software loads bank 0 word-by-word instead of shifting.
module trng_pool_buf #(
  parameter int IN_W  = 1,
  parameter int WORDS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IN_W-1:0]       src_data_i,
  input  logic                  src_vld_i,
  input  logic                  mode_sel_i,
  input  logic [1:0]            pp_opt_i,
  input  logic                  flush_i,
  input  logic                  sw_wr_i,
  input  logic [$clog2(WORDS)-1:0] sw_addr_i,
  input  logic [31:0]           sw_wdata_i,
  input  logic                  rd_req_i,
  input  logic [$clog2(WORDS)-1:0] rd_addr_i,
  input  logic                  drop_clr_i,
  output logic [31:0]           rd_data_o,
  output logic [32*WORDS-1:0]   pool_data_o,
  output logic                  pool_ready_o,
  output logic                  mode_chg_o,
  output logic                  pp_chg_o,
  output logic [15:0]           drop_cnt_o
);
  localparam int BANK_BITS = 32 * WORDS;
  localparam int AW        = $clog2(WORDS);
  localparam int CW        = $clog2(BANK_BITS + 1);

  logic [BANK_BITS-1:0] bank_q [2];
  logic [BANK_BITS-1:0] bank_d [2];
  logic [1:0]           full_q, full_d;
  logic                 fill_ptr_q, fill_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic [31:0]          rd_data_q, rd_data_d;
  logic                 mode_q;
  logic [1:0]           pp_q;

  logic          flush_v, accept_v, complete_v, release_v, drop_v;
  logic          other_rd, other_fill;
  logic [CW-1:0] bit_sum;
  logic [1:0]    rel_mask;
  logic [31:0]   rd_word [WORDS];

  assign mode_chg_o = mode_sel_i != mode_q;
  assign pp_chg_o   = pp_opt_i != pp_q;
  assign flush_v    = mode_chg_o | pp_chg_o | flush_i;

  assign other_rd   = ~rd_ptr_q;
  assign other_fill = ~fill_ptr_q;
  assign bit_sum    = bit_cnt_q + CW'(IN_W);
  assign accept_v   = !mode_sel_i && src_vld_i && !full_q[fill_ptr_q];
  assign complete_v = accept_v && (bit_sum == CW'(BANK_BITS));
  assign drop_v     = !mode_sel_i && src_vld_i && full_q[fill_ptr_q];
  assign release_v  = rd_req_i && (rd_addr_i == AW'(WORDS - 1)) && full_q[rd_ptr_q];
  assign rel_mask   = release_v ? (2'b01 << rd_ptr_q) : 2'b00;

  // Word 0 sits at the top of the bank so it holds the oldest shifted-in bits.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      assign rd_word[gi] = bank_q[rd_ptr_q][BANK_BITS-1-32*gi -: 32];
    end
  endgenerate

  always_comb begin
    bank_d     = bank_q;
    full_d     = full_q;
    fill_ptr_d = fill_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    bit_cnt_d  = bit_cnt_q;
    drop_cnt_d = drop_cnt_q;
    rd_data_d  = rd_req_i ? rd_word[rd_addr_i] : rd_data_q;
    if (flush_v) begin
      bank_d[0]  = '0;
      bank_d[1]  = '0;
      full_d     = 2'b00;
      fill_ptr_d = 1'b0;
      rd_ptr_d   = 1'b0;
      bit_cnt_d  = '0;
    end else begin
      if (drop_v && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      if (release_v) begin
        full_d[rd_ptr_q] = 1'b0;
        if (full_q[other_rd] || (complete_v && fill_ptr_q == other_rd)) rd_ptr_d = other_rd;
        if (full_q[fill_ptr_q]) begin
          fill_ptr_d = rd_ptr_q;
          bit_cnt_d  = '0;
        end
      end
      if (accept_v) begin
        bank_d[fill_ptr_q] = {bank_q[fill_ptr_q][BANK_BITS-IN_W-1:0], src_data_i};
        if (complete_v) begin
          full_d[fill_ptr_q] = 1'b1;
          bit_cnt_d          = '0;
          if ((full_q & ~rel_mask) == 2'b00) rd_ptr_d = fill_ptr_q;
          // Collection moves on only if the other bank is free; otherwise it stalls here.
          if (!full_q[other_fill] || (release_v && rd_ptr_q == other_fill)) fill_ptr_d = other_fill;
        end else begin
          bit_cnt_d = bit_sum;
        end
      end
      if (mode_sel_i && sw_wr_i) begin
        for (int k = 0; k < WORDS; k++) begin
          if (sw_addr_i == AW'(k)) bank_d[0][BANK_BITS-1-32*k -: 32] = sw_wdata_i;
        end
        if (sw_addr_i == AW'(WORDS - 1)) full_d[0] = 1'b1;
      end
    end
    if (drop_clr_i) drop_cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q[0]  <= '0;
      bank_q[1]  <= '0;
      full_q     <= 2'b00;
      fill_ptr_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      bit_cnt_q  <= '0;
      drop_cnt_q <= '0;
      rd_data_q  <= '0;
      mode_q     <= 1'b0;
      pp_q       <= 2'b00;
    end else begin
      bank_q[0]  <= bank_d[0];
      bank_q[1]  <= bank_d[1];
      full_q     <= full_d;
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      bit_cnt_q  <= bit_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      rd_data_q  <= rd_data_d;
      mode_q     <= mode_sel_i;
      pp_q       <= pp_opt_i;
    end
  end

  assign rd_data_o    = rd_data_q;
  assign pool_data_o  = bank_q[rd_ptr_q];
  assign pool_ready_o = |full_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_trng_pool_buf.sv
// Directed bench for trng_pool_buf: a 1-bit/8-word instance and an 8-bit/4-word instance.
module tb_trng_pool_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: IN_W=1, WORDS=8
  logic         a_src_data = 1'b0, a_src_vld = 1'b0, a_mode_sel = 1'b0, a_flush = 1'b0;
  logic [1:0]   a_pp_opt = 2'b00;
  logic         a_sw_wr = 1'b0, a_rd_req = 1'b0, a_drop_clr = 1'b0;
  logic [2:0]   a_sw_addr = 3'd0, a_rd_addr = 3'd0;
  logic [31:0]  a_sw_wdata = 32'd0;
  logic [31:0]  a_rd_data;
  logic [255:0] a_pool_data;
  logic         a_pool_ready, a_mode_chg, a_pp_chg;
  logic [15:0]  a_drop_cnt;

  // Instance B: IN_W=8, WORDS=4
  logic [7:0]   b_src_data = 8'd0;
  logic         b_src_vld = 1'b0;
  logic [1:0]   b_rd_addr = 2'd0;
  logic [31:0]  b_rd_data;
  logic [127:0] b_pool_data;
  logic         b_pool_ready, b_mode_chg, b_pp_chg;
  logic [15:0]  b_drop_cnt;

  logic [255:0] exp_v;

  trng_pool_buf #(.IN_W(1), .WORDS(8)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .src_data_i(a_src_data), .src_vld_i(a_src_vld),
    .mode_sel_i(a_mode_sel), .pp_opt_i(a_pp_opt), .flush_i(a_flush),
    .sw_wr_i(a_sw_wr), .sw_addr_i(a_sw_addr), .sw_wdata_i(a_sw_wdata),
    .rd_req_i(a_rd_req), .rd_addr_i(a_rd_addr), .drop_clr_i(a_drop_clr),
    .rd_data_o(a_rd_data), .pool_data_o(a_pool_data), .pool_ready_o(a_pool_ready),
    .mode_chg_o(a_mode_chg), .pp_chg_o(a_pp_chg), .drop_cnt_o(a_drop_cnt)
  );

  trng_pool_buf #(.IN_W(8), .WORDS(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .src_data_i(b_src_data), .src_vld_i(b_src_vld),
    .mode_sel_i(1'b0), .pp_opt_i(2'b00), .flush_i(1'b0),
    .sw_wr_i(1'b0), .sw_addr_i(2'd0), .sw_wdata_i(32'd0),
    .rd_req_i(1'b0), .rd_addr_i(b_rd_addr), .drop_clr_i(1'b0),
    .rd_data_o(b_rd_data), .pool_data_o(b_pool_data), .pool_ready_o(b_pool_ready),
    .mode_chg_o(b_mode_chg), .pp_chg_o(b_pp_chg), .drop_cnt_o(b_drop_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_rd_data", a_rd_data, 0);
    chk("rst_pool_data", a_pool_data, 0);
    chk("rst_pool_ready", a_pool_ready, 0);
    chk("rst_drop_cnt", a_drop_cnt, 0);
    chk("rst_b_pool_ready", b_pool_ready, 0);
    rst = 1'b0;
    tick();
    chk("idle_mode_chg", a_mode_chg, 0);

    // TRNG fill of bank 0 with alternating bits
    a_src_vld = 1'b1;
    for (int i = 0; i < 255; i++) begin
      a_src_data = 1'(i & 1);
      tick();
    end
    chk("fill255_ready", a_pool_ready, 0);
    a_src_data = 1'b1;
    tick();
    a_src_vld = 1'b0;
    chk("fill256_ready", a_pool_ready, 1);
    chk("fill256_pool", a_pool_data, {8{32'h55555555}});
    a_rd_req = 1'b1; a_rd_addr = 3'd0;
    tick();
    a_rd_req = 1'b0;
    chk("rd_word0", a_rd_data, 32'h55555555);

    // Fill bank 1 with ones, then overflow by 10
    a_src_vld = 1'b1; a_src_data = 1'b1;
    repeat (256) tick();
    chk("both_full_drop0", a_drop_cnt, 0);
    repeat (10) tick();
    a_src_vld = 1'b0;
    chk("drop10", a_drop_cnt, 10);
    chk("stall_pool_bank0", a_pool_data, {8{32'h55555555}});

    // Drain bank 0
    for (int k = 0; k < 8; k++) begin
      a_rd_req = 1'b1; a_rd_addr = 3'(k);
      tick();
      chk("drain_rd", a_rd_data, 32'h55555555);
    end
    a_rd_req = 1'b0;
    chk("drain_ready", a_pool_ready, 1);
    chk("drain_pool_bank1", a_pool_data, {256{1'b1}});

    // Complete bank 0 while releasing bank 1 in the same cycle
    a_src_vld = 1'b1; a_src_data = 1'b0;
    repeat (255) tick();
    a_src_data = 1'b1; a_rd_req = 1'b1; a_rd_addr = 3'd7;
    tick();
    a_rd_req = 1'b0; a_src_vld = 1'b0;
    chk("conc_rd_data", a_rd_data, 32'hFFFFFFFF);
    chk("conc_ready", a_pool_ready, 1);
    chk("conc_pool", a_pool_data, 256'h1);
    chk("conc_drop", a_drop_cnt, 10);

    // Fill pointer must now be bank 1
    a_src_vld = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a_src_data = 1'((i >> 1) & 1);
      tick();
    end
    a_src_data = 1'b1;
    tick();
    a_src_vld = 1'b0;
    chk("refill_drop11", a_drop_cnt, 11);
    chk("refill_pool", a_pool_data, 256'h1);
    a_rd_req = 1'b1; a_rd_addr = 3'd7;
    tick();
    a_rd_req = 1'b0;
    chk("rel0_rd_data", a_rd_data, 32'h00000001);
    chk("rel0_pool", a_pool_data, {8{32'h33333333}});
    chk("rel0_ready", a_pool_ready, 1);

    a_drop_clr = 1'b1;
    tick();
    a_drop_clr = 1'b0;
    chk("drop_clr", a_drop_cnt, 0);

    // pp_opt change mid-fill
    a_src_vld = 1'b1; a_src_data = 1'b1;
    repeat (100) tick();
    a_src_vld = 1'b0;
    a_pp_opt = 2'b01;
    #1;
    chk("pp_chg_high", a_pp_chg, 1);
    chk("pp_mode_chg_low", a_mode_chg, 0);
    tick();
    chk("pp_chg_low", a_pp_chg, 0);
    chk("pp_flush_ready", a_pool_ready, 0);
    chk("pp_flush_pool", a_pool_data, 0);
    a_src_vld = 1'b1;
    for (int i = 0; i < 255; i++) begin
      a_src_data = 1'((i >> 2) & 1);
      tick();
    end
    chk("pp_fill255_ready", a_pool_ready, 0);
    a_src_data = 1'b1;
    tick();
    a_src_vld = 1'b0;
    chk("pp_fill256_ready", a_pool_ready, 1);
    chk("pp_fill_word0", a_pool_data[255:224], 32'h0F0F0F0F);

    // DRNG load
    a_mode_sel = 1'b1;
    #1;
    chk("mode_chg_high", a_mode_chg, 1);
    tick();
    chk("mode_chg_low", a_mode_chg, 0);
    chk("drng_flush_ready", a_pool_ready, 0);
    a_sw_wr = 1'b1; a_src_vld = 1'b1; a_src_data = 1'b1;
    exp_v = '0;
    for (int k = 0; k < 8; k++) begin
      a_sw_addr = 3'(k);
      a_sw_wdata = 32'hA5A50000 + 32'(k);
      exp_v = {exp_v[223:0], 32'hA5A50000 + 32'(k)};
      tick();
      if (k == 6) chk("drng_w6_ready", a_pool_ready, 0);
    end
    a_sw_wr = 1'b0; a_src_vld = 1'b0;
    chk("drng_ready", a_pool_ready, 1);
    chk("drng_word7", a_pool_data[31:0], 32'hA5A50007);
    chk("drng_pool", a_pool_data, exp_v);
    chk("drng_no_drop", a_drop_cnt, 0);
    a_rd_req = 1'b1; a_rd_addr = 3'd3;
    tick();
    a_rd_req = 1'b0;
    chk("drng_rd3", a_rd_data, 32'hA5A50003);

    // Reset aborts everything
    rst = 1'b1; a_mode_sel = 1'b0; a_pp_opt = 2'b00;
    tick();
    chk("rst2_pool", a_pool_data, 0);
    chk("rst2_ready", a_pool_ready, 0);
    chk("rst2_rd_data", a_rd_data, 0);
    rst = 1'b0;
    tick();

    // Instance B: byte samples, 4-word banks, drop saturation
    b_src_vld = 1'b1;
    for (int i = 0; i < 15; i++) begin
      b_src_data = 8'(i);
      tick();
    end
    chk("b_fill15_ready", b_pool_ready, 0);
    b_src_data = 8'h0F;
    tick();
    chk("b_fill16_ready", b_pool_ready, 1);
    chk("b_pool", b_pool_data, 128'h000102030405060708090A0B0C0D0E0F);
    repeat (16) tick();
    chk("b_full_drop0", b_drop_cnt, 0);
    repeat (65534) tick();
    chk("b_drop_fffe", b_drop_cnt, 16'hFFFE);
    tick();
    chk("b_drop_ffff", b_drop_cnt, 16'hFFFF);
    repeat (70000 - 65535) tick();
    b_src_vld = 1'b0;
    chk("b_drop_sat", b_drop_cnt, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
